// File: rtl/npu_pkg.sv
// Shared NPU control types and latency helpers used by the systolic sequencer.
package npu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_t;

    // Depth of the psum path from the top row to the bottom of the array.
    function automatic int calc_lat_a(input int rows, input int pe_lat);
        return rows * pe_lat;
    endfunction

    // Stream count at which the last column emits its last result.
    function automatic int calc_s_end(input int k_len, input int cols, input int lat_a);
        return k_len + cols + lat_a - 2;
    endfunction

endpackage

// File: rtl/skew_mask.sv
// Diagonal window mask: lane j is valid while 0 <= s - OFFSET - j < k_len.
module skew_mask #(
    parameter int N      = 4,
    parameter int OFFSET = 1,
    parameter int SW     = 13,
    parameter int KW     = 8
) (
    input  logic [SW-1:0] i_s,
    input  logic [KW-1:0] i_k_len,
    output logic [N-1:0]  o_mask
);

    localparam int DW = SW + 1;

    logic signed [DW-1:0] w_k;
    assign w_k = $signed({{(DW-KW){1'b0}}, i_k_len});

    // One spare bit keeps the difference signed so early lanes read as negative.
    for (genvar j = 0; j < N; j++) begin : g_lane
        logic signed [DW-1:0] w_d;
        assign w_d       = $signed({1'b0, i_s}) - $signed(DW'(OFFSET + j));
        assign o_mask[j] = !w_d[DW-1] && (w_d < w_k);
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary array sequencer: weight load, skewed activation stream,
// drain with per-column result validity, then a one-cycle done pulse.
module systolic_ctrl
    import npu_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int PE_LAT = 2,
    parameter int KW     = 8,
    parameter int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    output logic            busy,
    output logic            done,
    output logic            w_rd_en,
    output logic [AW-1:0]   w_rd_addr,
    output logic            w_load,
    output logic            a_rd_en,
    output logic [KW-1:0]   a_rd_addr,
    output logic [ROWS-1:0] a_row_valid,
    output logic [COLS-1:0] o_col_valid
);

    localparam int LAT_A = calc_lat_a(ROWS, PE_LAT);
    localparam int SW    = KW + $clog2(COLS + LAT_A) + 1;

    ctrl_state_t r_state, w_state_nxt;
    logic [SW-1:0] r_cnt, w_cnt_nxt, w_s_end, w_klen_ext, w_klen_nxt_ext;
    logic [KW-1:0] r_klen, w_klen_nxt;
    logic [ROWS-1:0] w_row_mask;
    logic [COLS-1:0] w_col_mask;

    logic            r_busy, r_done, r_w_rd_en, r_w_load, r_a_rd_en;
    logic [AW-1:0]   r_w_rd_addr;
    logic [KW-1:0]   r_a_rd_addr;
    logic [ROWS-1:0] r_a_row_valid;
    logic [COLS-1:0] r_o_col_valid;

    logic            w_busy, w_done, w_w_rd_en, w_w_load, w_a_rd_en, w_in_stream;
    logic [AW-1:0]   w_w_rd_addr;
    logic [KW-1:0]   w_a_rd_addr;
    logic [ROWS-1:0] w_a_row_valid;
    logic [COLS-1:0] w_o_col_valid;

    assign w_klen_ext     = {{(SW-KW){1'b0}}, r_klen};
    assign w_klen_nxt_ext = {{(SW-KW){1'b0}}, w_klen_nxt};
    assign w_s_end        = SW'(calc_s_end(int'(r_klen), COLS, LAT_A));

    // One shared counter: weight-row index in LOAD_W, stream count s afterwards.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_klen_nxt  = r_klen;
        case (r_state)
            ST_IDLE: begin
                if (start && (k_len != '0)) begin
                    w_state_nxt = ST_LOAD_W;
                    w_cnt_nxt   = '0;
                    w_klen_nxt  = k_len;
                end
            end
            ST_LOAD_W: begin
                if (r_cnt == SW'(ROWS)) begin
                    w_state_nxt = ST_STREAM;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + SW'(1);
                end
            end
            ST_STREAM: begin
                w_cnt_nxt = r_cnt + SW'(1);
                if (r_cnt == w_klen_ext - SW'(1)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_cnt_nxt = r_cnt + SW'(1);
                if (r_cnt == w_s_end) w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    skew_mask #(.N(ROWS), .OFFSET(1), .SW(SW), .KW(KW)) u_row_mask (
        .i_s     (w_cnt_nxt),
        .i_k_len (w_klen_nxt),
        .o_mask  (w_row_mask)
    );

    skew_mask #(.N(COLS), .OFFSET(LAT_A), .SW(SW), .KW(KW)) u_col_mask (
        .i_s     (w_cnt_nxt),
        .i_k_len (w_klen_nxt),
        .o_mask  (w_col_mask)
    );

    // Outputs are decoded from the next state so the registered copy lines up with it.
    always_comb begin
        w_in_stream   = (w_state_nxt == ST_STREAM) || (w_state_nxt == ST_DRAIN);
        w_busy        = (w_state_nxt != ST_IDLE);
        w_done        = (w_state_nxt == ST_DONE);
        w_w_rd_en     = (w_state_nxt == ST_LOAD_W) && (w_cnt_nxt < SW'(ROWS));
        w_w_rd_addr   = w_w_rd_en ? (AW'(ROWS - 1) - w_cnt_nxt[AW-1:0]) : '0;
        w_w_load      = (w_state_nxt == ST_LOAD_W) && (w_cnt_nxt != '0);
        w_a_rd_en     = w_in_stream && (w_cnt_nxt < w_klen_nxt_ext);
        w_a_rd_addr   = w_a_rd_en ? w_cnt_nxt[KW-1:0] : '0;
        w_a_row_valid = w_in_stream ? w_row_mask : '0;
        w_o_col_valid = w_in_stream ? w_col_mask : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_klen        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_w_rd_en     <= 1'b0;
            r_w_rd_addr   <= '0;
            r_w_load      <= 1'b0;
            r_a_rd_en     <= 1'b0;
            r_a_rd_addr   <= '0;
            r_a_row_valid <= '0;
            r_o_col_valid <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_klen        <= w_klen_nxt;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_w_rd_en     <= w_w_rd_en;
            r_w_rd_addr   <= w_w_rd_addr;
            r_w_load      <= w_w_load;
            r_a_rd_en     <= w_a_rd_en;
            r_a_rd_addr   <= w_a_rd_addr;
            r_a_row_valid <= w_a_row_valid;
            r_o_col_valid <= w_o_col_valid;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign w_rd_en     = r_w_rd_en;
    assign w_rd_addr   = r_w_rd_addr;
    assign w_load      = r_w_load;
    assign a_rd_en     = r_a_rd_en;
    assign a_rd_addr   = r_a_rd_addr;
    assign a_row_valid = r_a_row_valid;
    assign o_col_valid = r_o_col_valid;

endmodule
